// File: rtl/spmv_pkg.sv
// Shared encodings and default constants for the SpMV read scheduler.
package spmv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_VEC_LEN = 16;
  localparam int DEF_RD_LAT  = 2;
  localparam int DEF_BASE    = 0;

  localparam logic [1:0] CAP_NONE   = 2'b00;
  localparam logic [1:0] CAP_FIRST  = 2'b01;
  localparam logic [1:0] CAP_SECOND = 2'b10;

endpackage

// File: rtl/spmv_port_seq.sv
// Two-phase address sequencer for one M10K port, followed by a RD_LAT-deep
// pipeline that turns each issued address into a capture strobe and index
// exactly when the memory word arrives.
module spmv_port_seq
  import spmv_pkg::*;
#(
  parameter int               ADDR_W = DEF_ADDR_W,
  parameter int               RD_LAT = DEF_RD_LAT,
  parameter logic [ADDR_W-1:0] BASE0 = '0,
  parameter logic [ADDR_W-1:0] BASE1 = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   len0,
  input  logic [ADDR_W:0]   len1,
  output logic [ADDR_W-1:0] addr,
  output logic              req,
  output logic [1:0]        cap,
  output logic [ADDR_W-1:0] cap_idx,
  output logic              fin
);

  // Counts are one bit wider than addresses so rows+1 never overflows.
  logic [ADDR_W:0]   len0_q;
  logic [ADDR_W:0]   len1_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   cur_len;
  logic              phase_end;
  phase_t            phase;

  logic [1:0]        cap_in;
  logic [ADDR_W-1:0] idx_in;
  logic [1:0]        cap_pipe [RD_LAT];
  logic [ADDR_W-1:0] idx_pipe [RD_LAT];

  assign idx_inc   = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign cur_len   = (phase == PH_FIRST) ? len0_q : len1_q;
  assign phase_end = (idx_inc == cur_len);
  assign fin       = !req || (phase_end && ((phase == PH_SECOND) || (len1_q == '0)));

  // Walk phase 0 then phase 1 back-to-back, skipping empty phases and holding the last address when finished.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      req    <= 1'b0;
      addr   <= '0;
      phase  <= PH_FIRST;
      idx    <= '0;
      len0_q <= '0;
      len1_q <= '0;
    end else if (start) begin
      len0_q <= len0;
      len1_q <= len1;
      idx    <= '0;
      if (len0 != '0) begin
        req   <= 1'b1;
        phase <= PH_FIRST;
        addr  <= BASE0;
      end else if (len1 != '0) begin
        req   <= 1'b1;
        phase <= PH_SECOND;
        addr  <= BASE1;
      end else begin
        req   <= 1'b0;
      end
    end else if (req) begin
      if (!phase_end) begin
        idx  <= idx_inc;
        addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if ((phase == PH_FIRST) && (len1_q != '0)) begin
        phase <= PH_SECOND;
        idx   <= '0;
        addr  <= BASE1;
      end else begin
        req <= 1'b0;
      end
    end
  end

  // Tag the address issued this cycle with its buffer select and element index.
  always_comb begin
    cap_in = CAP_NONE;
    idx_in = '0;
    if (req) begin
      cap_in = (phase == PH_FIRST) ? CAP_FIRST : CAP_SECOND;
      idx_in = idx[ADDR_W-1:0];
    end
  end

  // Delay the tag by RD_LAT cycles so it lines up with the memory read data.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < RD_LAT; k++) begin
        cap_pipe[k] <= CAP_NONE;
        idx_pipe[k] <= '0;
      end
    end else begin
      cap_pipe[0] <= cap_in;
      idx_pipe[0] <= idx_in;
      for (int k = 1; k < RD_LAT; k++) begin
        cap_pipe[k] <= cap_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

  assign cap     = cap_pipe[RD_LAT-1];
  assign cap_idx = idx_pipe[RD_LAT-1];

endmodule

// File: rtl/spmv_read_scheduler.sv
// Read scheduler for the SpMV engine: streams vector/value reads on port A and
// col-index/row-ptr reads on port B, then waits out the read latency.
module spmv_read_scheduler
  import spmv_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter int               VEC_LEN  = DEF_VEC_LEN,
  parameter int               RD_LAT   = DEF_RD_LAT,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(DEF_BASE),
  parameter logic [ADDR_W-1:0] VAL_BASE = ADDR_W'(DEF_BASE),
  parameter logic [ADDR_W-1:0] COL_BASE = ADDR_W'(DEF_BASE),
  parameter logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(DEF_BASE)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_nnz,
  input  logic [ADDR_W-1:0] i_rows,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic              o_req_a,
  output logic              o_req_b,
  output logic [1:0]        o_cap_a,
  output logic [1:0]        o_cap_b,
  output logic [ADDR_W-1:0] o_cap_idx_a,
  output logic [ADDR_W-1:0] o_cap_idx_b,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(RD_LAT - 1);

  if ((RD_LAT < 1) || (DATA_W < 1)) begin : g_param_check
    $error("spmv_read_scheduler: RD_LAT and DATA_W must be at least 1");
  end

  state_t            state;
  logic [DCNT_W-1:0] drain_cnt;
  logic              start_go;
  logic              fin_a;
  logic              fin_b;
  logic [ADDR_W:0]   len_vec;
  logic [ADDR_W:0]   len_nnz;
  logic [ADDR_W:0]   len_ptr;

  // Start is only honoured in IDLE; the sequencers latch their counts on this pulse.
  assign start_go = (state == ST_IDLE) && i_start;
  assign len_vec  = (ADDR_W+1)'(VEC_LEN);
  assign len_nnz  = {1'b0, i_nnz};
  assign len_ptr  = {1'b0, i_rows} + {{ADDR_W{1'b0}}, 1'b1};

  spmv_port_seq #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .BASE0  (VEC_BASE),
    .BASE1  (VAL_BASE)
  ) u_port_a (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .start   (start_go),
    .len0    (len_vec),
    .len1    (len_nnz),
    .addr    (o_addr_a),
    .req     (o_req_a),
    .cap     (o_cap_a),
    .cap_idx (o_cap_idx_a),
    .fin     (fin_a)
  );

  spmv_port_seq #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .BASE0  (COL_BASE),
    .BASE1  (PTR_BASE)
  ) u_port_b (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .start   (start_go),
    .len0    (len_nnz),
    .len1    (len_ptr),
    .addr    (o_addr_b),
    .req     (o_req_b),
    .cap     (o_cap_b),
    .cap_idx (o_cap_idx_b),
    .fin     (fin_b)
  );

  // Top-level control: run until both ports are out of addresses, drain RD_LAT cycles, pulse done.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state  <= ST_RUN;
            o_busy <= 1'b1;
          end
        end
        ST_RUN: begin
          if (fin_a && fin_b) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DCNT_LAST) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + {{(DCNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_done <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_read_scheduler.sv
// Directed bench for spmv_read_scheduler: cycle-by-cycle expected outputs for
// a normal run, an nnz=0 run, a rows=0 run, ignored starts and a mid-run reset.
module tb_spmv_read_scheduler;

  localparam int ADDR_W = 10;

  logic              i_clk;
  logic              i_rstn;
  logic              i_start;
  logic [ADDR_W-1:0] i_nnz;
  logic [ADDR_W-1:0] i_rows;
  logic [ADDR_W-1:0] o_addr_a;
  logic [ADDR_W-1:0] o_addr_b;
  logic              o_req_a;
  logic              o_req_b;
  logic [1:0]        o_cap_a;
  logic [1:0]        o_cap_b;
  logic [ADDR_W-1:0] o_cap_idx_a;
  logic [ADDR_W-1:0] o_cap_idx_b;
  logic              o_busy;
  logic              o_done;

  int checks = 0;
  int errors = 0;

  spmv_read_scheduler #(
    .DATA_W   (16),
    .ADDR_W   (ADDR_W),
    .VEC_LEN  (4),
    .RD_LAT   (2),
    .VEC_BASE (10'd100),
    .VAL_BASE (10'd1022),
    .COL_BASE (10'd200),
    .PTR_BASE (10'd300)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_nnz       (i_nnz),
    .i_rows      (i_rows),
    .o_addr_a    (o_addr_a),
    .o_addr_b    (o_addr_b),
    .o_req_a     (o_req_a),
    .o_req_b     (o_req_b),
    .o_cap_a     (o_cap_a),
    .o_cap_b     (o_cap_b),
    .o_cap_idx_a (o_cap_idx_a),
    .o_cap_idx_b (o_cap_idx_b),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic applyStimulus(input logic rstn, input logic start,
                               input int nnz, input int rows);
    i_rstn  = rstn;
    i_start = start;
    i_nnz   = ADDR_W'(nnz);
    i_rows  = ADDR_W'(rows);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed %0d expected %0d", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag,
                             input int req_a, input int addr_a,
                             input int req_b, input int addr_b,
                             input int cap_a, input int idx_a,
                             input int cap_b, input int idx_b,
                             input int busy,  input int done);
    chk(tag, "req_a",   16'(o_req_a),     16'(req_a));
    chk(tag, "addr_a",  16'(o_addr_a),    16'(addr_a));
    chk(tag, "req_b",   16'(o_req_b),     16'(req_b));
    chk(tag, "addr_b",  16'(o_addr_b),    16'(addr_b));
    chk(tag, "cap_a",   16'(o_cap_a),     16'(cap_a));
    chk(tag, "cidx_a",  16'(o_cap_idx_a), 16'(idx_a));
    chk(tag, "cap_b",   16'(o_cap_b),     16'(cap_b));
    chk(tag, "cidx_b",  16'(o_cap_idx_b), 16'(idx_b));
    chk(tag, "busy",    16'(o_busy),      16'(busy));
    chk(tag, "done",    16'(o_done),      16'(done));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 0, 0);
    step();
    step();
    checkOutput("reset", 0,0, 0,0, 0,0, 0,0, 0,0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    step();
    checkOutput("idle", 0,0, 0,0, 0,0, 0,0, 0,0);

    // Run 1: nnz=3, rows=2; VAL addresses wrap 1022,1023,0; stray starts and nnz change ignored.
    applyStimulus(1'b1, 1'b1, 3, 2);
    step(); checkOutput("r1 t1", 1,100,  1,200, 0,0, 0,0, 1,0);
    applyStimulus(1'b1, 1'b0, 3, 2);
    step(); checkOutput("r1 t2", 1,101,  1,201, 0,0, 0,0, 1,0);
    applyStimulus(1'b1, 1'b0, 7, 5);
    step(); checkOutput("r1 t3", 1,102,  1,202, 1,0, 1,0, 1,0);
    applyStimulus(1'b1, 1'b1, 7, 5);
    step(); checkOutput("r1 t4", 1,103,  1,300, 1,1, 1,1, 1,0);
    applyStimulus(1'b1, 1'b0, 7, 5);
    step(); checkOutput("r1 t5", 1,1022, 1,301, 1,2, 1,2, 1,0);
    step(); checkOutput("r1 t6", 1,1023, 1,302, 1,3, 2,0, 1,0);
    step(); checkOutput("r1 t7", 1,0,    0,302, 2,0, 2,1, 1,0);
    step(); checkOutput("r1 t8", 0,0,    0,302, 2,1, 2,2, 1,0);
    step(); checkOutput("r1 t9", 0,0,    0,302, 2,2, 0,0, 1,0);
    step(); checkOutput("r1 t10",0,0,    0,302, 0,0, 0,0, 0,1);
    applyStimulus(1'b1, 1'b1, 3, 2);
    step(); checkOutput("r1 t11",0,0,    0,302, 0,0, 0,0, 0,0);
    applyStimulus(1'b1, 1'b0, 3, 2);
    step(); checkOutput("r1 t12",0,0,    0,302, 0,0, 0,0, 0,0);

    // Run 2: nnz=0, rows=2 -- no VAL or COL phase at all.
    applyStimulus(1'b1, 1'b1, 0, 2);
    step(); checkOutput("r2 t1", 1,100, 1,300, 0,0, 0,0, 1,0);
    applyStimulus(1'b1, 1'b0, 0, 2);
    step(); checkOutput("r2 t2", 1,101, 1,301, 0,0, 0,0, 1,0);
    step(); checkOutput("r2 t3", 1,102, 1,302, 1,0, 2,0, 1,0);
    step(); checkOutput("r2 t4", 1,103, 0,302, 1,1, 2,1, 1,0);
    step(); checkOutput("r2 t5", 0,103, 0,302, 1,2, 2,2, 1,0);
    step(); checkOutput("r2 t6", 0,103, 0,302, 1,3, 0,0, 1,0);
    step(); checkOutput("r2 t7", 0,103, 0,302, 0,0, 0,0, 0,1);
    step(); checkOutput("r2 t8", 0,103, 0,302, 0,0, 0,0, 0,0);

    // Run 3: same as run 1 but reset asserted during t4; strobes in flight must vanish.
    applyStimulus(1'b1, 1'b1, 3, 2);
    step(); checkOutput("r3 t1", 1,100, 1,200, 0,0, 0,0, 1,0);
    applyStimulus(1'b1, 1'b0, 3, 2);
    step(); checkOutput("r3 t2", 1,101, 1,201, 0,0, 0,0, 1,0);
    step(); checkOutput("r3 t3", 1,102, 1,202, 1,0, 1,0, 1,0);
    step(); checkOutput("r3 t4", 1,103, 1,300, 1,1, 1,1, 1,0);
    applyStimulus(1'b0, 1'b0, 3, 2);
    #3;
    checkOutput("r3 t4 mid", 1,103, 1,300, 1,1, 1,1, 1,0);
    step(); checkOutput("r3 t5", 0,0, 0,0, 0,0, 0,0, 0,0);
    applyStimulus(1'b1, 1'b0, 3, 2);
    step(); checkOutput("r3 t6", 0,0, 0,0, 0,0, 0,0, 0,0);
    step(); checkOutput("r3 t7", 0,0, 0,0, 0,0, 0,0, 0,0);
    step(); checkOutput("r3 t8", 0,0, 0,0, 0,0, 0,0, 0,0);

    // Run 4: after the reset, nnz=1, rows=0 -- still exactly one row-ptr word.
    applyStimulus(1'b1, 1'b1, 1, 0);
    step(); checkOutput("r4 t1", 1,100,  1,200, 0,0, 0,0, 1,0);
    applyStimulus(1'b1, 1'b0, 1, 0);
    step(); checkOutput("r4 t2", 1,101,  1,300, 0,0, 0,0, 1,0);
    step(); checkOutput("r4 t3", 1,102,  0,300, 1,0, 1,0, 1,0);
    step(); checkOutput("r4 t4", 1,103,  0,300, 1,1, 2,0, 1,0);
    step(); checkOutput("r4 t5", 1,1022, 0,300, 1,2, 0,0, 1,0);
    step(); checkOutput("r4 t6", 0,1022, 0,300, 1,3, 0,0, 1,0);
    step(); checkOutput("r4 t7", 0,1022, 0,300, 2,0, 0,0, 1,0);
    step(); checkOutput("r4 t8", 0,1022, 0,300, 0,0, 0,0, 0,1);
    step(); checkOutput("r4 t9", 0,1022, 0,300, 0,0, 0,0, 0,0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
